// File: rtl/imem_loader_if.sv
// Handshake and memory-write bundle between a byte-stream source and imem_loader.
// The loader uses the slave modport; the stream source / bench uses master.
interface imem_loader_if #(
    parameter int CNT_W = 16
);
    logic             Start;
    logic [CNT_W-1:0] WordCount;
    logic [7:0]       ByteIn;
    logic             ByteValid;
    logic             ByteReady;
    logic             IMWrite;
    logic [63:0]      IMAddr;
    logic [31:0]      IMData;
    logic             Busy;
    logic             Done;
    logic             Error;
    logic             CoreHold;

    modport master (
        output Start, WordCount, ByteIn, ByteValid,
        input  ByteReady, IMWrite, IMAddr, IMData, Busy, Done, Error, CoreHold
    );

    modport slave (
        input  Start, WordCount, ByteIn, ByteValid,
        output ByteReady, IMWrite, IMAddr, IMData, Busy, Done, Error, CoreHold
    );
endinterface

// File: rtl/imem_loader.sv
// Assembles a little-endian byte stream into 32-bit words and writes them to instruction
// memory from address 0, holding the core until the image is committed.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH_WORDS = 64,
    parameter int CNT_W       = 16
) (
    input  logic          Clock,
    input  logic          Reset,
    imem_loader_if.slave  ldr
);
    localparam int AW = $clog2(DEPTH_WORDS) + 2;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        DONE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK,
`endif
        ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       byteIdx_q, byteIdx_d;
    logic [CNT_W-1:0] wordCnt_q, wordCnt_d;
    logic [CNT_W-1:0] wordTotal_q, wordTotal_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [31:0]      data_q, data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       xor_q, xor_d;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            byteIdx_q   <= '0;
            wordCnt_q   <= '0;
            wordTotal_q <= '0;
            addr_q      <= '0;
            data_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            byteIdx_q   <= byteIdx_d;
            wordCnt_q   <= wordCnt_d;
            wordTotal_q <= wordTotal_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q       <= xor_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        byteIdx_d   = byteIdx_q;
        wordCnt_d   = wordCnt_q;
        wordTotal_d = wordTotal_q;
        addr_d      = addr_q;
        data_d      = data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d       = xor_q;
`endif
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (ldr.Start) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d = '0;
`endif
                    if (ldr.WordCount == '0 || ldr.WordCount > CNT_W'(DEPTH_WORDS)) begin
                        state_d = ERROR;
                    end else begin
                        state_d     = RECV;
                        byteIdx_d   = '0;
                        wordCnt_d   = '0;
                        addr_d      = '0;
                        wordTotal_d = ldr.WordCount;
                    end
                end
            end
            RECV: begin
                if (ldr.ByteValid) begin
                    case (byteIdx_q)
                        2'd0: data_d[7:0]   = ldr.ByteIn;
                        2'd1: data_d[15:8]  = ldr.ByteIn;
                        2'd2: data_d[23:16] = ldr.ByteIn;
                        2'd3: data_d[31:24] = ldr.ByteIn;
                        default: ;
                    endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d = xor_q ^ ldr.ByteIn;
`endif
                    byteIdx_d = byteIdx_q + 2'd1;
                    if (byteIdx_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                addr_d    = addr_q + AW'(4);
                wordCnt_d = wordCnt_q + CNT_W'(1);
                if (wordCnt_q + CNT_W'(1) == wordTotal_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = CHK;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = RECV;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (ldr.ByteValid) begin
                    state_d = (ldr.ByteIn == xor_q) ? DONE : ERROR;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // All status outputs decode straight from the registered state, so they are glitch-free.
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign ldr.ByteReady = (state_q == RECV) || (state_q == CHK);
    assign ldr.Busy      = (state_q == RECV) || (state_q == WRITE) || (state_q == CHK);
`else
    assign ldr.ByteReady = (state_q == RECV);
    assign ldr.Busy      = (state_q == RECV) || (state_q == WRITE);
`endif
    assign ldr.IMWrite  = (state_q == WRITE);
    assign ldr.IMAddr   = {{(64 - AW){1'b0}}, addr_q};
    assign ldr.IMData   = data_q;
    assign ldr.Done     = (state_q == DONE);
    assign ldr.Error    = (state_q == ERROR);
    assign ldr.CoreHold = (state_q != DONE);
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of load vectors, hand-written corner sequences,
// and randomized loads checked against a byte-to-word reference model.
module tb_imem_loader;
    localparam int DEPTH = 64;

    logic Clock;
    logic Reset;

    imem_loader_if #(.CNT_W(16)) ldr ();

    imem_loader #(.DEPTH_WORDS(DEPTH), .CNT_W(16)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .ldr   (ldr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int passCount = 0;
    int totalCount = 0;

    logic [7:0]  img[$];
    logic [63:0] capAddr[$];
    logic [31:0] capData[$];
    int          gapAt = -1;
    int          chkOverride = -1;

    typedef struct {
        int wc;
        int maxGap;
        bit expDone;
        int expWrites;
    } vec_t;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        totalCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic failNow(input string name);
        totalCount++;
        $display("[TB] FAIL %s: got timeout, expected handshake", name);
    endtask

    // Every memory write is captured here and checked against the model after the load.
    always @(negedge Clock) begin
        if (ldr.IMWrite === 1'b1) begin
            capAddr.push_back(ldr.IMAddr);
            capData.push_back(ldr.IMData);
            checkOutput("wr_ready_low", {63'd0, ldr.ByteReady}, 64'd0);
            checkOutput("wr_busy", {63'd0, ldr.Busy}, 64'd1);
            checkOutput("wr_hold", {63'd0, ldr.CoreHold}, 64'd1);
        end
    end

    task automatic fillRandom(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back(8'($urandom));
    endtask

    task automatic pulseStart(input int wc);
        @(negedge Clock);
        ldr.ByteValid = 1'b0;
        ldr.Start     = 1'b1;
        ldr.WordCount = 16'(wc);
        @(negedge Clock);
        ldr.Start     = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge Clock);
            ldr.ByteIn    = b;
            ldr.ByteValid = 1'b1;
            if (ldr.ByteReady === 1'b1) begin
                ok = 1'b1;
                @(posedge Clock);
                #1 ldr.ByteValid = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input int first, input int n, input int maxGap);
        bit ok;
        for (int i = first; i < first + n; i++) begin
            if (maxGap > 0) begin
                repeat ($urandom_range(0, maxGap)) begin
                    @(negedge Clock);
                    ldr.ByteValid = 1'b0;
                end
            end
            if (i == gapAt) begin
                repeat (3) begin
                    @(negedge Clock);
                    ldr.ByteValid = 1'b0;
                    checkOutput("gap_ready", {63'd0, ldr.ByteReady}, 64'd1);
                    checkOutput("gap_nowrite", {63'd0, ldr.IMWrite}, 64'd0);
                end
            end
            sendByte(img[i], ok);
            if (!ok) begin
                failNow("byte_handshake");
                return;
            end
        end
    endtask

    task automatic checkResetState(input string name);
        checkOutput({name, "_imwrite"}, {63'd0, ldr.IMWrite}, 64'd0);
        checkOutput({name, "_imaddr"}, ldr.IMAddr, 64'd0);
        checkOutput({name, "_imdata"}, {32'd0, ldr.IMData}, 64'd0);
        checkOutput({name, "_ready"}, {63'd0, ldr.ByteReady}, 64'd0);
        checkOutput({name, "_busy"}, {63'd0, ldr.Busy}, 64'd0);
        checkOutput({name, "_done"}, {63'd0, ldr.Done}, 64'd0);
        checkOutput({name, "_error"}, {63'd0, ldr.Error}, 64'd0);
        checkOutput({name, "_hold"}, {63'd0, ldr.CoreHold}, 64'd1);
    endtask

    // Reference model: word i is bytes 4i..4i+3 little-endian, written at byte address 4i.
    task automatic finishAndCheck(input int wc, input bit fed, input bit expDone, input int expWrites);
        bit fin;
`ifdef IMEM_LOADER_CHECKSUM_EN
        bit ok;
        logic [7:0] c;
        if (fed) begin
            c = 8'd0;
            for (int i = 0; i < wc * 4; i++) c ^= img[i];
            if (chkOverride >= 0) c = 8'(chkOverride);
            sendByte(c, ok);
            if (!ok) failNow("chk_handshake");
        end
`endif
        fin = 1'b0;
        for (int t = 0; t < 40 && !fin; t++) begin
            @(negedge Clock);
            if (ldr.Done === 1'b1 || ldr.Error === 1'b1) fin = 1'b1;
        end
        if (!fin) failNow("completion");
        checkOutput("done", {63'd0, ldr.Done}, {63'd0, expDone});
        checkOutput("error", {63'd0, ldr.Error}, {63'd0, !expDone});
        checkOutput("corehold", {63'd0, ldr.CoreHold}, {63'd0, !expDone});
        checkOutput("busy_idle", {63'd0, ldr.Busy}, 64'd0);
        checkOutput("nwrites", 64'(capAddr.size()), 64'(expWrites));
        for (int i = 0; i < expWrites && i < capAddr.size(); i++) begin
            checkOutput("waddr", capAddr[i], 64'(4 * i));
            checkOutput("wdata", {32'd0, capData[i]},
                        {32'd0, img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]});
        end
    endtask

    task automatic runLoad(input int wc, input int maxGap, input bit expDone, input int expWrites);
        bit fed;
        capAddr.delete();
        capData.delete();
        fed = (wc >= 1 && wc <= DEPTH);
        pulseStart(wc);
        if (fed) applyStimulus(0, wc * 4, maxGap);
        finishAndCheck(wc, fed, expDone, expWrites);
    endtask

    initial begin
        vec_t vecs[8];
        logic [31:0] d0, d1;
        int wc;
        bit legal;

        vecs = '{
            '{1, 0, 1'b1, 1},
            '{2, 2, 1'b1, 2},
            '{0, 0, 1'b0, 0},
            '{65, 0, 1'b0, 0},
            '{64, 0, 1'b1, 64},
            '{32'hFFFF, 0, 1'b0, 0},
            '{5, 3, 1'b1, 5},
            '{100, 0, 1'b0, 0}
        };

        Reset = 1'b1;
        ldr.Start = 1'b0;
        ldr.WordCount = '0;
        ldr.ByteIn = '0;
        ldr.ByteValid = 1'b0;
        repeat (2) @(negedge Clock);
        checkResetState("reset");
        Reset = 1'b0;

        // Fixed two-word image with known words.
        img = '{8'h13, 8'h00, 8'h80, 8'hD2, 8'h20, 8'h00, 8'h00, 8'h8B};
        runLoad(2, 0, 1'b1, 2);
        d0 = (capData.size() > 0) ? capData[0] : 32'hx;
        d1 = (capData.size() > 1) ? capData[1] : 32'hx;
        checkOutput("t1_word0", {32'd0, d0}, 64'h00000000D2800013);
        checkOutput("t1_word1", {32'd0, d1}, 64'h000000008B000020);

        // Same image with a three-cycle stall between bytes 2 and 3.
        gapAt = 2;
        runLoad(2, 0, 1'b1, 2);
        gapAt = -1;

        for (int v = 0; v < 8; v++) begin
            fillRandom(DEPTH * 4);
            runLoad(vecs[v].wc, vecs[v].maxGap, vecs[v].expDone, vecs[v].expWrites);
        end

        // Reset in the middle of a two-word load, then a fresh one-word load.
        capAddr.delete();
        capData.delete();
        fillRandom(8);
        pulseStart(2);
        applyStimulus(0, 6, 0);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        checkResetState("t4");
        checkOutput("t4_writes", 64'(capAddr.size()), 64'd1);
        Reset = 1'b0;
        fillRandom(4);
        runLoad(1, 0, 1'b1, 1);

        // Start during RECV is ignored; the three-word load completes normally.
        capAddr.delete();
        capData.delete();
        fillRandom(12);
        pulseStart(3);
        applyStimulus(0, 2, 0);
        pulseStart(1);
        checkOutput("t5_busy", {63'd0, ldr.Busy}, 64'd1);
        applyStimulus(2, 10, 0);
        finishAndCheck(3, 1'b1, 1'b1, 3);
        fillRandom(4);
        runLoad(1, 0, 1'b1, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        img = '{8'h01, 8'h02, 8'h04, 8'h08};
        chkOverride = 8'h0F;
        runLoad(1, 0, 1'b1, 1);
        chkOverride = 8'h0E;
        runLoad(1, 0, 1'b0, 1);
        chkOverride = -1;
`endif

        for (int r = 0; r < 8; r++) begin
            wc = $urandom_range(1, 8);
            if ($urandom_range(0, 4) == 0) wc = ($urandom_range(0, 1) == 0) ? 0 : DEPTH + 1 + $urandom_range(0, 200);
            legal = (wc >= 1 && wc <= DEPTH);
            fillRandom(DEPTH * 4);
            runLoad(wc, 2, legal, legal ? wc : 0);
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end
endmodule
